lcm_beacon_filter: RTL and testbench
====================================

// Module: lcm_beacon_filter
// PURPOSE
// Upstream classifier for lcm: receives the UM packet stream (134-bit words), detects beacon packets by
// Ethernet type (and optionally destination MAC) and steers them to lcm; all other packets go to a
// bypass port toward esw. Fixed 2-stage delay line; routing decided per packet and held to its tail.
// Keeps saturating statistics counters for lcm report use.
// PARAMETERS
// BEACON_ETYPE  16'h1662  Ethertype identifying beacon packets
// MATCH_DMAC    1'b1      1: beacon also requires dst MAC == in_local_mac_id or ff:ff:ff:ff:ff:ff
// PORTS
// clk                 in   1    clock
// rst_n               in   1    async active-low reset
// in_data             in   134  [133:132] 01 head/11 body/10 tail; [131:128] byte-valid; [127:0] payload
// in_data_wr          in   1    word strobe
// in_data_valid       in   1    1 = keep packet, 0 = discard (meaningful with in_data_valid_wr)
// in_data_valid_wr    in   1    packet-status strobe, coincides with the tail word
// pktin_ready         out  1    may start a new packet next cycle
// in_local_mac_id     in   48   local MAC for dst match
// lcm_pktin_ready     in   1    ready from lcm
// byp_pktin_ready     in   1    ready from bypass consumer
// out_lcm_data/_wr/_valid/_valid_wr      out 134/1/1/1  beacon stream to lcm
// out_byp_data/_wr/_valid/_valid_wr      out 134/1/1/1  non-beacon stream
// beacon_cnt, bypass_cnt, discard_cnt    out 32 each    packet counters
// BEHAVIOUR
// - Reset: all outputs 0 except pktin_ready=0 for first cycle, then follows rule below; counters 0; FSM IDLE.
// - Word 0 = metadata; word 1 = Ethernet header: dst [127:80], src [79:32], ethertype [31:16].
// - Delay line: stage0/stage1 regs hold data, wr, valid, valid_wr. Every word exits exactly 2 cycles
//   after entry, on exactly one output port; other port's wr/valid_wr stay 0, data holds last value.
// - FSM: IDLE -> WAIT_HDR on head word (head=tail single-word pkt -> decide BYPASS immediately).
//   WAIT_HDR -> LCM if word1 ethertype==BEACON_ETYPE and (MATCH_DMAC==0 or dst match), else BYPASS;
//   decision registered as dest when word1 enters stage0, i.e. while word0 sits in stage0 -> stage1
//   boundary, so word0 already routed by dest. LCM/BYPASS -> IDLE when tail leaves stage1.
// - dest bound to packet: head in stage1 uses new dest; a new head entering behind a tail does not
//   change routing of that tail (dest pipelined per stage).
// - pktin_ready = lcm_pktin_ready & byp_pktin_ready & (no packet in progress at input side or tail
//   seen this cycle). Upstream starts packets only when ready; once started, no stall, words may
//   be gapped (in_data_wr low); gaps propagate unchanged.
// - Back-to-back: head may enter the cycle after a tail; must sustain 1 word/cycle.
// - Counters update when valid_wr leaves stage1: valid=1 -> beacon_cnt or bypass_cnt by dest;
//   valid=0 -> discard_cnt (packet still forwarded with valid=0). Saturate at 32'hFFFF_FFFF.
// - Malformed: body/tail with no open packet -> dropped, not forwarded, discard_cnt+1. Head while
//   packet open -> previous packet forced closed (forwarded valid_wr=1,valid=0), discard_cnt+1.
// - Reset mid-packet: everything cleared asynchronously; partial packet lost, no output strobes.
// TESTING
// 1 4-word pkt, ethertype 0x1662, dst=local MAC -> 4 words on out_lcm 2 cycles later; beacon_cnt=1.
// 2 Same with ethertype 0x0800 -> all words on out_byp only; bypass_cnt=1; out_lcm_data_wr never 1.
// 3 MATCH_DMAC=1, ethertype 0x1662, dst=00:11:22:33:44:55!=local -> bypass; dst=broadcast -> lcm.
// 4 Beacon pkt immediately followed (next cycle) by non-beacon pkt -> no word misrouted, 1/cycle.
// 5 valid_wr with valid=0 on tail -> forwarded on chosen port with valid=0; discard_cnt=1.
// 6 lcm_pktin_ready=0 -> pktin_ready=0; rst_n low mid-packet -> outputs/counters 0 next edge.

Source files
------------

// File: rtl/lcm_beacon_filter.sv
// lcm_beacon_filter
//   Splits the UM packet stream into beacon packets (to lcm) and everything
//   else (bypass toward esw). Every accepted word leaves exactly two cycles
//   after it entered, on exactly one port. The routing decision is taken from
//   the Ethernet header in word 1 and is carried per stage, so a packet keeps
//   its route through to its tail even if the next packet starts right behind it.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   in_data[133:0]                [133:132] 01 head / 11 body / 10 tail,
//                                 [131:128] byte valid, [127:0] payload
//   in_data_wr                    word strobe
//   in_data_valid, _valid_wr      packet status (keep/discard), strobed with the tail
//   pktin_ready                   upstream may start a new packet next cycle
//   in_local_mac_id[47:0]         local MAC for destination match
//   lcm_pktin_ready               downstream ready from lcm
//   byp_pktin_ready               downstream ready from bypass consumer
//   out_lcm_*                     beacon stream
//   out_byp_*                     non-beacon stream
//   beacon_cnt, bypass_cnt,
//   discard_cnt[31:0]             saturating packet counters
module lcm_beacon_filter #(
    parameter logic [15:0] BEACON_ETYPE = 16'h1662,
    parameter bit          MATCH_DMAC   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] in_data,
    input  logic         in_data_wr,
    input  logic         in_data_valid,
    input  logic         in_data_valid_wr,
    output logic         pktin_ready,
    input  logic [47:0]  in_local_mac_id,
    input  logic         lcm_pktin_ready,
    input  logic         byp_pktin_ready,
    output logic [133:0] out_lcm_data,
    output logic         out_lcm_data_wr,
    output logic         out_lcm_data_valid,
    output logic         out_lcm_data_valid_wr,
    output logic [133:0] out_byp_data,
    output logic         out_byp_data_wr,
    output logic         out_byp_data_valid,
    output logic         out_byp_data_valid_wr,
    output logic [31:0]  beacon_cnt,
    output logic [31:0]  bypass_cnt,
    output logic [31:0]  discard_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_HDR, LCM, BYPASS} state_t;

    state_t state;
    logic   rst_done;

    // Stage 0. dest: 1 = lcm, 0 = bypass. pend marks a head whose route is
    // still unknown; it is resolved as it moves into stage 1.
    logic [133:0] s0_data;
    logic         s0_wr, s0_valid, s0_vwr, s0_dest, s0_pend;
    logic         s0_abort, s0_adest, s0_drop;

    // Stage 1 bookkeeping; the data/strobe part of stage 1 is the output ports.
    logic         s1_beacon, s1_bypass;
    logic [1:0]   s1_disc;

    logic         is_head, is_word, is_tail, pkt_open;
    logic         dst_ok, hdr_lcm, hdr_now, pend_dest, s1_dest;
    logic         to_lcm, to_byp, lcm_end, byp_end;
    logic [47:0]  dst_mac;

    assign is_head  = in_data_wr && (in_data[133:132] == 2'b01);
    assign is_word  = in_data_wr && (in_data[133:132] != 2'b01);
    assign is_tail  = in_data_wr && (in_data[133:132] == 2'b10);
    assign pkt_open = (state != IDLE);

    assign dst_mac  = in_data[127:80];
    assign dst_ok   = !MATCH_DMAC || (dst_mac == in_local_mac_id) ||
                      (dst_mac == 48'hFFFF_FFFF_FFFF);
    assign hdr_lcm  = (in_data[31:16] == BEACON_ETYPE) && dst_ok;

    // Word 1 at the input while the head sits in stage 0: its verdict routes
    // the head as well. If word 1 is late (gap) the head must leave without a
    // verdict, so the whole packet falls back to bypass.
    assign hdr_now   = (state == WAIT_HDR) && is_word;
    assign pend_dest = hdr_now && hdr_lcm;
    assign s1_dest   = s0_pend ? pend_dest : s0_dest;

    assign pktin_ready = rst_done && lcm_pktin_ready && byp_pktin_ready &&
                         (!pkt_open || is_tail);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    // Input side: packet framing FSM and stage 0 load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s0_data  <= '0;
            s0_wr    <= 1'b0;
            s0_valid <= 1'b0;
            s0_vwr   <= 1'b0;
            s0_dest  <= 1'b0;
            s0_pend  <= 1'b0;
            s0_abort <= 1'b0;
            s0_adest <= 1'b0;
            s0_drop  <= 1'b0;
        end else begin
            s0_wr    <= 1'b0;
            s0_valid <= 1'b0;
            s0_vwr   <= 1'b0;
            s0_dest  <= 1'b0;
            s0_pend  <= 1'b0;
            s0_abort <= 1'b0;
            s0_adest <= 1'b0;
            s0_drop  <= 1'b0;
            if (is_head) begin
                s0_wr    <= 1'b1;
                s0_data  <= in_data;
                // A head inside an open packet closes that packet as discarded
                // on whatever port it was using (bypass if still undecided).
                s0_abort <= pkt_open;
                s0_adest <= (state == LCM);
                if (in_data_valid_wr) begin
                    // Single-word packet: no header word, always bypass.
                    s0_vwr   <= 1'b1;
                    s0_valid <= in_data_valid;
                    state    <= IDLE;
                end else begin
                    s0_pend  <= 1'b1;
                    state    <= WAIT_HDR;
                end
            end else if (is_word) begin
                if (!pkt_open) begin
                    s0_drop <= 1'b1;    // orphan body/tail: counted, not forwarded
                end else begin
                    s0_wr    <= 1'b1;
                    s0_data  <= in_data;
                    s0_vwr   <= in_data_valid_wr;
                    s0_valid <= in_data_valid & in_data_valid_wr;
                    s0_dest  <= (state == WAIT_HDR) ? hdr_lcm : (state == LCM);
                    if (is_tail)
                        state <= IDLE;
                    else if (state == WAIT_HDR)
                        state <= hdr_lcm ? LCM : BYPASS;
                end
            end else if (state == WAIT_HDR) begin
                state <= BYPASS;        // head already left undecided
            end
        end
    end

    assign to_lcm  = s0_wr  &&  s1_dest;
    assign to_byp  = s0_wr  && !s1_dest;
    assign lcm_end = s0_vwr &&  s1_dest;
    assign byp_end = s0_vwr && !s1_dest;

    // Stage 1 = output registers. Idle port keeps its last data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lcm_data          <= '0;
            out_lcm_data_wr       <= 1'b0;
            out_lcm_data_valid    <= 1'b0;
            out_lcm_data_valid_wr <= 1'b0;
            out_byp_data          <= '0;
            out_byp_data_wr       <= 1'b0;
            out_byp_data_valid    <= 1'b0;
            out_byp_data_valid_wr <= 1'b0;
            s1_beacon             <= 1'b0;
            s1_bypass             <= 1'b0;
            s1_disc               <= 2'd0;
        end else begin
            if (to_lcm) out_lcm_data <= s0_data;
            if (to_byp) out_byp_data <= s0_data;
            out_lcm_data_wr       <= to_lcm;
            out_byp_data_wr       <= to_byp;
            // A forced close rides along as a bare valid_wr with valid=0.
            out_lcm_data_valid_wr <= lcm_end || (s0_abort &&  s0_adest);
            out_byp_data_valid_wr <= byp_end || (s0_abort && !s0_adest);
            out_lcm_data_valid    <= lcm_end && s0_valid;
            out_byp_data_valid    <= byp_end && s0_valid;
            s1_beacon             <= lcm_end && s0_valid;
            s1_bypass             <= byp_end && s0_valid;
            s1_disc               <= {1'b0, s0_vwr && !s0_valid} +
                                     {1'b0, s0_abort} + {1'b0, s0_drop};
        end
    end

    // Counters follow stage 1 by one cycle.
    logic [32:0] beacon_sum, bypass_sum, discard_sum;
    assign beacon_sum  = {1'b0, beacon_cnt}  + {32'd0, s1_beacon};
    assign bypass_sum  = {1'b0, bypass_cnt}  + {32'd0, s1_bypass};
    assign discard_sum = {1'b0, discard_cnt} + {31'd0, s1_disc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beacon_cnt  <= '0;
            bypass_cnt  <= '0;
            discard_cnt <= '0;
        end else begin
            beacon_cnt  <= beacon_sum[32]  ? 32'hFFFF_FFFF : beacon_sum[31:0];
            bypass_cnt  <= bypass_sum[32]  ? 32'hFFFF_FFFF : bypass_sum[31:0];
            discard_cnt <= discard_sum[32] ? 32'hFFFF_FFFF : discard_sum[31:0];
        end
    end

endmodule

// File: tb/tb_lcm_beacon_filter.sv
// Bench for lcm_beacon_filter: packet-level reference model. Each packet's
// route is computed from its header fields, each word is scheduled on its
// port two cycles after it is driven, and packet outcomes are tallied into
// expected counter totals.
module tb_lcm_beacon_filter;

    localparam int N = 4096;
    localparam logic [15:0] BEACON = 16'h1662;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [133:0] in_data = '0;
    logic         in_data_wr = 1'b0, in_data_valid = 1'b0, in_data_valid_wr = 1'b0;
    logic         pktin_ready;
    logic [47:0]  local_mac = 48'h02AB_CD00_0042;
    logic         lcm_rdy = 1'b1, byp_rdy = 1'b1;
    logic [133:0] lcm_data, byp_data;
    logic         lcm_wr, lcm_val, lcm_vwr, byp_wr, byp_val, byp_vwr;
    logic [31:0]  beacon_cnt, bypass_cnt, discard_cnt;

    always #5 clk = ~clk;

    lcm_beacon_filter dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_data_wr(in_data_wr),
        .in_data_valid(in_data_valid), .in_data_valid_wr(in_data_valid_wr),
        .pktin_ready(pktin_ready), .in_local_mac_id(local_mac),
        .lcm_pktin_ready(lcm_rdy), .byp_pktin_ready(byp_rdy),
        .out_lcm_data(lcm_data), .out_lcm_data_wr(lcm_wr),
        .out_lcm_data_valid(lcm_val), .out_lcm_data_valid_wr(lcm_vwr),
        .out_byp_data(byp_data), .out_byp_data_wr(byp_wr),
        .out_byp_data_valid(byp_val), .out_byp_data_valid_wr(byp_vwr),
        .beacon_cnt(beacon_cnt), .bypass_cnt(bypass_cnt), .discard_cnt(discard_cnt)
    );

    // Expected output schedule, port 0 = lcm, port 1 = bypass.
    bit           e_wr [2][N];
    bit           e_vwr[2][N];
    bit           e_val[2][N];
    logic [133:0] e_data[2][N];

    int  cur;
    int  total = 0, bad = 0;
    int  exp_beacon = 0, exp_bypass = 0, exp_disc = 0;
    bit  abort_pend = 0, abort_port = 0;

    task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cur, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) begin
                e_wr[p][i] = 0; e_vwr[p][i] = 0; e_val[p][i] = 0; e_data[p][i] = '0;
            end
        cur = 0;
        exp_beacon = 0; exp_bypass = 0; exp_disc = 0;
        abort_pend = 0;
    endtask

    task automatic idle_in();
        in_data_wr = 0; in_data_valid = 0; in_data_valid_wr = 0;
    endtask

    // One clock: check the outputs for the current cycle, advance.
    task automatic tick();
        @(negedge clk);
        chk("lcm_wr",  lcm_wr,  e_wr[0][cur]);
        chk("byp_wr",  byp_wr,  e_wr[1][cur]);
        chk("lcm_vwr", lcm_vwr, e_vwr[0][cur]);
        chk("byp_vwr", byp_vwr, e_vwr[1][cur]);
        if (e_wr[0][cur])  chk("lcm_data",  lcm_data, e_data[0][cur]);
        if (e_wr[1][cur])  chk("byp_data",  byp_data, e_data[1][cur]);
        if (e_vwr[0][cur]) chk("lcm_valid", lcm_val,  e_val[0][cur]);
        if (e_vwr[1][cur]) chk("byp_valid", byp_val,  e_val[1][cur]);
        @(posedge clk);
        #1;
        cur++;
        idle_in();
    endtask

    function automatic bit route_lcm(input int len, input logic [15:0] et, input logic [47:0] dst);
        return (len > 1) && (et == BEACON) &&
               ((dst == local_mac) || (dst == 48'hFFFF_FFFF_FFFF));
    endfunction

    function automatic logic [133:0] mk_word(input logic [1:0] code, input int idx,
                                             input logic [15:0] et, input logic [47:0] dst);
        logic [127:0] pl;
        pl = {$urandom, $urandom, $urandom, $urandom};
        if (idx == 1) pl = {dst, pl[79:32], et, pl[15:0]};
        return {code, 4'($urandom), pl};
    endfunction

    // Full packet; len==1 is a head carrying the status strobe.
    task automatic send_pkt(input int len, input logic [15:0] et, input logic [47:0] dst,
                            input bit v, input bit gaps);
        bit           dest;
        int           port;
        logic [1:0]   code;
        logic [133:0] w;
        if (!abort_pend) chk("ready_start", pktin_ready, 1'b1);
        if (abort_pend && len < 2) len = 2;
        dest = route_lcm(len, et, dst);
        port = dest ? 0 : 1;
        for (int i = 0; i < len; i++) begin
            code = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
            w = mk_word(code, i, et, dst);
            in_data = w; in_data_wr = 1;
            in_data_valid_wr = (i == len - 1);
            in_data_valid    = (i == len - 1) ? v : 1'b0;
            e_wr[port][cur + 2] = 1; e_data[port][cur + 2] = w;
            if (i == 0 && abort_pend) begin
                e_vwr[abort_port][cur + 2] = 1; e_val[abort_port][cur + 2] = 0;
                exp_disc++;
                abort_pend = 0;
            end
            if (i == len - 1) begin
                e_vwr[port][cur + 2] = 1; e_val[port][cur + 2] = v;
                if (!v)       exp_disc++;
                else if (dest) exp_beacon++;
                else           exp_bypass++;
            end else if (i >= 1) begin
                #1 chk("ready_mid", pktin_ready, 1'b0);
            end
            tick();
            if (gaps && i >= 1 && i < len - 1 && $urandom_range(0, 1) == 1) tick();
        end
    endtask

    // Packet cut short by the next head (k = 1 or 2 words sent).
    task automatic send_partial(input int k, input logic [15:0] et, input logic [47:0] dst);
        bit dest;
        int port;
        logic [133:0] w;
        dest = (k >= 2) && route_lcm(2, et, dst);
        port = dest ? 0 : 1;
        for (int i = 0; i < k; i++) begin
            w = mk_word((i == 0) ? 2'b01 : 2'b11, i, et, dst);
            in_data = w; in_data_wr = 1;
            e_wr[port][cur + 2] = 1; e_data[port][cur + 2] = w;
            tick();
        end
        abort_pend = 1; abort_port = port;
    endtask

    task automatic stray_word();
        in_data = mk_word(2'b10, 2, 16'h0, 48'h0); in_data_wr = 1;
        in_data_valid_wr = 1; in_data_valid = 1;
        exp_disc++;
        tick();
    endtask

    task automatic check_cnt(input string tag);
        repeat (4) tick();
        chk({tag, "_beacon"},  beacon_cnt,  exp_beacon);
        chk({tag, "_bypass"},  bypass_cnt,  exp_bypass);
        chk({tag, "_discard"}, discard_cnt, exp_disc);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_lcm_data"}, lcm_data, 134'd0);
        chk({tag, "_byp_data"}, byp_data, 134'd0);
        chk({tag, "_strobes"}, {lcm_wr, lcm_val, lcm_vwr, byp_wr, byp_val, byp_vwr}, 6'd0);
        chk({tag, "_cnts"}, {beacon_cnt, bypass_cnt, discard_cnt}, 96'd0);
        chk({tag, "_ready"}, pktin_ready, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1;
        #1 chk("ready_first_cycle", pktin_ready, 1'b0);
        @(posedge clk);
        #1 chk("ready_after_reset", pktin_ready, 1'b1);
        clear_model();
    endtask

    logic [47:0] other_mac = 48'h0011_2233_4455;
    logic [47:0] bcast     = 48'hFFFF_FFFF_FFFF;

    initial begin
        clear_model();
        #1 check_all_zero("reset");
        release_reset();

        // Directed: beacon, non-beacon, dst filtering, back-to-back, discard.
        send_pkt(4, BEACON, local_mac, 1, 0);
        check_cnt("t1");
        send_pkt(4, 16'h0800, local_mac, 1, 0);
        check_cnt("t2");
        send_pkt(3, BEACON, other_mac, 1, 0);
        send_pkt(3, BEACON, bcast, 1, 0);
        check_cnt("t3");
        send_pkt(3, BEACON, local_mac, 1, 0);
        send_pkt(2, 16'h0800, local_mac, 1, 0);
        send_pkt(1, BEACON, local_mac, 1, 0);
        send_pkt(2, BEACON, bcast, 1, 0);
        check_cnt("t4");
        send_pkt(4, BEACON, local_mac, 0, 0);
        send_pkt(3, 16'h86DD, other_mac, 0, 0);
        check_cnt("t5");

        // Malformed: orphan words and packets cut short by a new head.
        stray_word();
        send_partial(2, BEACON, local_mac);
        send_pkt(3, 16'h0800, other_mac, 1, 0);
        send_partial(1, BEACON, local_mac);
        send_pkt(2, BEACON, local_mac, 1, 0);
        check_cnt("malformed");

        // Readiness follows both downstream readies.
        lcm_rdy = 0;
        #1 chk("ready_lcm_low", pktin_ready, 1'b0);
        lcm_rdy = 1; byp_rdy = 0;
        #1 chk("ready_byp_low", pktin_ready, 1'b0);
        byp_rdy = 1;
        #1 chk("ready_restored", pktin_ready, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int          len, r;
            logic [15:0] et;
            logic [47:0] dst;
            len = $urandom_range(1, 6);
            et  = ($urandom_range(0, 9) < 7) ? BEACON : 16'($urandom);
            r   = $urandom_range(0, 2);
            dst = (r == 0) ? local_mac : ((r == 1) ? bcast : {$urandom, 16'($urandom)});
            r   = $urandom_range(0, 9);
            if (r == 0) stray_word();
            else if (r == 1) send_partial($urandom_range(1, 2), et, dst);
            send_pkt(len, et, dst, $urandom_range(0, 4) != 0, 1);
            repeat ($urandom_range(0, 2)) tick();
        end
        check_cnt("random");

        // Reset in the middle of a packet.
        send_pkt(2, BEACON, local_mac, 1, 0);
        in_data = mk_word(2'b01, 0, BEACON, local_mac); in_data_wr = 1;
        tick();
        in_data = mk_word(2'b11, 1, BEACON, local_mac); in_data_wr = 1;
        @(negedge clk);
        rst_n = 0;
        #1 check_all_zero("mid_reset");
        idle_in();
        repeat (2) @(posedge clk);
        #1 check_all_zero("held_reset");
        release_reset();
        send_pkt(3, BEACON, bcast, 1, 0);
        check_cnt("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
